// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD message sequencer: FSM state encoding and
// width helpers used to size the item bus and the shared timer.
package lcd_seq_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_DB     = 3'd1;
    localparam logic [2:0] LATCH     = 3'd2;
    localparam logic [2:0] START     = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] DWELL     = 3'd5;

    // Items are numbered 1..n, so the bus must also hold the value n itself.
    function automatic int item_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Down-counter shared by the dwell and lcd-timeout phases; a load overrides
// counting, otherwise it decrements and parks at zero.
module lcd_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Background item scan plus urgent-message pre-emption in front of the lcd
// driver; one message in flight at a time, with dwell between messages.
module lcd_msg_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int NUM_ITEMS      = 3,
    parameter int QTY_W          = 3,
    parameter int PRICE_W        = 8,
    parameter int MSG_W          = 4,
    parameter int SCAN_MSG_BASE  = 0,
    parameter int DWELL_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int ITEM_W        = item_width(NUM_ITEMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_en,
    input  logic               cyclic,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MSG_W-1:0]   req_msg,
    input  logic [ITEM_W-1:0]  req_item,
    output logic               db_rd,
    output logic [ITEM_W-1:0]  db_addr,
    input  logic [QTY_W-1:0]   db_qty,
    input  logic [PRICE_W-1:0] db_price,
    output logic               lcd_start,
    input  logic               lcd_done,
    output logic [ITEM_W-1:0]  lcd_item,
    output logic [QTY_W-1:0]   lcd_qty,
    output logic [PRICE_W-1:0] lcd_price,
    output logic [MSG_W-1:0]   lcd_msg_index,
    output logic               busy,
    output logic               pass_done,
    output logic               lcd_timeout
);

    localparam int TMR_W        = timer_width(DWELL_CYCLES, TIMEOUT_CYCLES);
    localparam int DWELL_LOAD   = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;
    localparam int TIMEOUT_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [2:0]        state, next_state;
    logic [ITEM_W-1:0] item_q, ptr;
    logic [MSG_W-1:0]  msg_q, scan_msg;
    logic              is_scan_q, armed;
    logic              accept, scan_go, leave_wait, wrap;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_load_value, tmr_value;

    // Gated by rst_n so the handshake is closed while reset is held.
    assign req_ready  = (state == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign scan_go    = (state == IDLE) && !req_valid && scan_en && armed;
    assign scan_msg   = MSG_W'(SCAN_MSG_BASE) + MSG_W'(ptr);

    // A timed-out message still counts as shown, so both exits advance the scan.
    assign leave_wait = (state == WAIT_DONE) && (lcd_done || tmr_zero);
    assign wrap       = leave_wait && is_scan_q && (ptr == ITEM_W'(NUM_ITEMS));

    assign db_rd       = (state == RD_DB);
    assign db_addr     = db_rd ? item_q : '0;
    assign lcd_start   = (state == START);
    assign busy        = (state != IDLE);
    assign pass_done   = wrap;
    assign lcd_timeout = (state == WAIT_DONE) && !lcd_done && tmr_zero;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        next_state     = state;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state)
            IDLE:      if (accept || scan_go) next_state = RD_DB;
            RD_DB:     next_state = LATCH;
            LATCH:     next_state = START;
            START: begin
                next_state     = WAIT_DONE;
                tmr_load       = 1'b1;
                tmr_load_value = TMR_W'(TIMEOUT_LOAD);
            end
            WAIT_DONE: begin
                if (leave_wait) begin
                    if (DWELL_CYCLES == 0) begin
                        next_state = IDLE;
                    end else begin
                        next_state     = DWELL;
                        tmr_load       = 1'b1;
                        tmr_load_value = TMR_W'(DWELL_LOAD);
                    end
                end
            end
            DWELL:     if (tmr_zero) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            item_q    <= '0;
            msg_q     <= '0;
            is_scan_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                item_q    <= req_item;
                msg_q     <= req_msg;
                is_scan_q <= 1'b0;
            end else if (scan_go) begin
                item_q    <= ptr;
                msg_q     <= scan_msg;
                is_scan_q <= 1'b1;
            end
        end
    end

    // A one-shot pass disarms on wrap and re-arms once scan_en is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= ITEM_W'(1);
            armed <= 1'b1;
        end else begin
            if (leave_wait && is_scan_q) begin
                ptr <= wrap ? ITEM_W'(1) : ptr + ITEM_W'(1);
            end
            if (wrap && !cyclic) begin
                armed <= 1'b0;
            end else if (!scan_en) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_item      <= '0;
            lcd_qty       <= '0;
            lcd_price     <= '0;
            lcd_msg_index <= '0;
        end else if (state == LATCH) begin
            lcd_item      <= item_q;
            lcd_qty       <= db_qty;
            lcd_price     <= db_price;
            lcd_msg_index <= msg_q;
        end
    end

    lcd_seq_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Scoreboard bench for lcd_msg_sequencer: synchronous item-database model,
// lcd driver model answering 10 cycles after start, expectations in a queue.
module tb_lcd_msg_sequencer;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [1:0] item;
        logic [2:0] qty;
        logic [7:0] price;
        logic [3:0] msg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en, cyclic, req_valid, req_ready;
    logic [3:0] req_msg;
    logic [1:0] req_item;
    logic       db_rd;
    logic [1:0] db_addr;
    logic [2:0] db_qty;
    logic [7:0] db_price;
    logic       lcd_start, lcd_done;
    logic [1:0] lcd_item;
    logic [2:0] lcd_qty;
    logic [7:0] lcd_price;
    logic [3:0] lcd_msg_index;
    logic       busy, pass_done, lcd_timeout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_starts = 0, n_pass = 0, n_tmo = 0;
    int   last_start_cyc = 0, tmo_cyc = 0;
    logic prev_start = 1'b0;
    logic lcd_resp_en = 1'b1;
    int   lcd_cnt;
    exp_t exp_q[$];
    exp_t last_exp = '{item: 2'd0, qty: 3'd0, price: 8'd0, msg: 4'd0};

    lcd_msg_sequencer #(
        .NUM_ITEMS      (3),
        .QTY_W          (3),
        .PRICE_W        (8),
        .MSG_W          (4),
        .SCAN_MSG_BASE  (0),
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_en       (scan_en),
        .cyclic        (cyclic),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_msg       (req_msg),
        .req_item      (req_item),
        .db_rd         (db_rd),
        .db_addr       (db_addr),
        .db_qty        (db_qty),
        .db_price      (db_price),
        .lcd_start     (lcd_start),
        .lcd_done      (lcd_done),
        .lcd_item      (lcd_item),
        .lcd_qty       (lcd_qty),
        .lcd_price     (lcd_price),
        .lcd_msg_index (lcd_msg_index),
        .busy          (busy),
        .pass_done     (pass_done),
        .lcd_timeout   (lcd_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] price_of(input logic [1:0] i);
        case (i)
            2'd0:    return 8'd99;
            2'd1:    return 8'd15;
            default: return 8'd16;
        endcase
    endfunction

    // Read data is valid only in the cycle after db_rd; garbage otherwise.
    always @(posedge clk) begin
        if (db_rd) begin
            db_qty   <= 3'd5;
            db_price <= price_of(db_addr);
        end else begin
            db_qty   <= 3'd0;
            db_price <= 8'hEE;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_cnt  <= 0;
            lcd_done <= 1'b0;
        end else begin
            lcd_done <= 1'b0;
            if (lcd_start && lcd_resp_en) begin
                lcd_cnt <= 9;
            end else if (lcd_cnt > 0) begin
                lcd_cnt <= lcd_cnt - 1;
                if (lcd_cnt == 1) lcd_done <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] item, input logic [3:0] msg);
        exp_t e;
        e.item  = item;
        e.qty   = 3'd5;
        e.price = price_of(item);
        e.msg   = msg;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per lcd_start and watches the pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_start) check("start_width", {31'd0, lcd_start}, 0);
            if (lcd_start) begin
                n_starts++;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("start_unexpected", exp_q.size(), 1);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("lcd_item",  {30'd0, lcd_item},      {30'd0, last_exp.item});
                    check("lcd_qty",   {29'd0, lcd_qty},       {29'd0, last_exp.qty});
                    check("lcd_price", {24'd0, lcd_price},     {24'd0, last_exp.price});
                    check("lcd_msg",   {28'd0, lcd_msg_index}, {28'd0, last_exp.msg});
                end
            end
            if (lcd_done) begin
                check("item_stable", {30'd0, lcd_item},      {30'd0, last_exp.item});
                check("msg_stable",  {28'd0, lcd_msg_index}, {28'd0, last_exp.msg});
            end
            if (pass_done) n_pass++;
            if (lcd_timeout) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            prev_start = lcd_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic wait_starts(input int target, input string tag);
        int k = 0;
        while (n_starts < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, (n_starts >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, busy}, 0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send_req(input logic [3:0] msg, input logic [1:0] item, output int acc_cyc);
        int k = 0;
        req_msg   = msg;
        req_item  = item;
        req_valid = 1'b1;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("req_accept", {31'd0, req_ready}, 1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, s, acc;
        rst_n = 1'b0; scan_en = 1'b1; cyclic = 1'b1;
        req_valid = 1'b0; req_msg = '0; req_item = '0;
        repeat (3) @(negedge clk);

        // Reset state, then a cyclic scan of items 1..3 back to 1.
        check("rst_busy",      {31'd0, busy},      0);
        check("rst_req_ready", {31'd0, req_ready}, 0);
        check("rst_lcd_start", {31'd0, lcd_start}, 0);
        check("rst_db_rd",     {31'd0, db_rd},     0);
        push_exp(2'd1, 4'd1); push_exp(2'd2, 4'd2); push_exp(2'd3, 4'd3); push_exp(2'd1, 4'd1);
        c0 = cyc;
        rst_n = 1'b1;
        wait_starts(1, "t1_first_start");
        check("t1_latency", last_start_cyc - c0, 3);
        s = last_start_cyc;
        wait_starts(2, "t1_second_start");
        check("t1_period", last_start_cyc - s, 18);
        wait_starts(4, "t1_wrap_start");
        check("t1_pass_done", n_pass, 1);

        // scan_en dropped mid-message: it completes, nothing new starts.
        s = last_start_cyc;
        scan_en = 1'b0;
        wait_cyc(s + 14);
        check("t1_busy_in_dwell", {31'd0, busy}, 1);
        wait_cyc(s + 15);
        check("t1_idle_after_dwell", {31'd0, busy}, 0);
        wait_cyc(s + 45);
        check("t1_scan_off", n_starts, 4);

        // Urgent request wins over the scan at ptr=2; scan resumes at item 2.
        cyclic = 1'b0;
        push_exp(2'd2, 4'd9); push_exp(2'd2, 4'd2); push_exp(2'd3, 4'd3);
        scan_en = 1'b1;
        send_req(4'd9, 2'd2, acc);
        wait_starts(5, "t3_req_start");
        check("t3_req_latency", last_start_cyc - acc, 3);
        wait_starts(7, "t3_scan_done");
        wait_idle("t3_idle");
        check("t3_pass_done", n_pass, 2);
        c0 = cyc;
        wait_cyc(c0 + 40);
        check("t2_one_shot_stops", n_starts, 7);

        // Re-arm by dropping scan_en; new pass starts at item 1.
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(2'd1, 4'd1); push_exp(2'd2, 4'd2); push_exp(2'd3, 4'd3);
        c0 = cyc;
        scan_en = 1'b1;
        wait_starts(8, "t2_rearm_start");
        check("t2_rearm_latency", last_start_cyc - c0, 3);
        wait_starts(10, "t2_pass_end");

        // Request raised during DWELL waits for IDLE and is not lost.
        s = last_start_cyc;
        wait_cyc(s + 12);
        check("t4_ready_in_dwell", {31'd0, req_ready}, 0);
        push_exp(2'd1, 4'd12);
        send_req(4'd12, 2'd1, acc);
        check("t4_accept_cycle", acc - s, 15);
        wait_starts(11, "t4_req_start");
        check("t4_req_latency", last_start_cyc - acc, 3);
        wait_idle("t4_idle");
        check("t4_pass_done", n_pass, 3);

        // Out-of-range item 0 is read and shown as given.
        push_exp(2'd0, 4'd15);
        send_req(4'd15, 2'd0, acc);
        wait_starts(12, "item0_start");
        wait_idle("item0_idle");
        c0 = cyc;
        wait_cyc(c0 + 30);
        check("item0_no_scan", n_starts, 12);
        check("no_timeout_yet", n_tmo, 0);

        // lcd never answers: timeout at WAIT_DONE cycle 64, scan still advances.
        lcd_resp_en = 1'b0;
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(2'd1, 4'd1); push_exp(2'd2, 4'd2);
        scan_en = 1'b1;
        wait_starts(13, "t5_start");
        s = last_start_cyc;
        c0 = 0;
        while (n_tmo == 0 && c0 < 200) begin
            @(negedge clk);
            c0++;
        end
        check("t5_timeout_seen", n_tmo, 1);
        check("t5_timeout_cycle", tmo_cyc - s, TIMEOUT);
        lcd_resp_en = 1'b1;
        wait_starts(14, "t5_next_start");
        check("t5_next_start_cycle", last_start_cyc - s, TIMEOUT + DWELL + 4);

        // Reset during WAIT_DONE: outputs clear at once, scan restarts at item 1.
        s = last_start_cyc;
        wait_cyc(s + 5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy",      {31'd0, busy},           0);
        check("t6_req_ready", {31'd0, req_ready},      0);
        check("t6_lcd_start", {31'd0, lcd_start},      0);
        check("t6_db_rd",     {31'd0, db_rd},          0);
        check("t6_lcd_item",  {30'd0, lcd_item},       0);
        check("t6_lcd_qty",   {29'd0, lcd_qty},        0);
        check("t6_lcd_price", {24'd0, lcd_price},      0);
        check("t6_lcd_msg",   {28'd0, lcd_msg_index},  0);
        exp_q.delete();
        push_exp(2'd1, 4'd1); push_exp(2'd2, 4'd2); push_exp(2'd3, 4'd3);
        repeat (2) @(negedge clk);
        c0 = cyc;
        rst_n = 1'b1;
        wait_starts(15, "t6_restart");
        check("t6_restart_latency", last_start_cyc - c0, 3);
        wait_starts(17, "t6_pass_end");
        wait_idle("t6_idle");
        check("t6_pass_done", n_pass, 4);
        check("timeout_total", n_tmo, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
